// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
// Shared types and constants for the counter_ctrl programmable timer.
//   cmd_op_t      : command opcodes carried on cmd_op
//   state_t       : controller run state
//   MATCH_CNT_MAX : saturation value of match_count
//   sat_inc8      : saturating 8-bit increment used for match_count
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_START_ONESHOT  = 2'b00,
    CMD_START_PERIODIC = 2'b01,
    CMD_STOP           = 2'b10,
    CMD_NOP            = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ONESHOT  = 2'b01,
    PERIODIC = 2'b10
  } state_t;

  localparam logic [7:0] MATCH_CNT_MAX = 8'hFF;

  // Increment that sticks at MATCH_CNT_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == MATCH_CNT_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/counter_ctrl_count_core.sv
// count_core
// Counter datapath for counter_ctrl: holds the running count and the
// latched terminal count (limit).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : force count to 0 (has priority over advance)
//   advance     : step the count; wraps to 0 when it equals the limit
//   load_limit  : capture limit_in into the limit register
//   limit_in    : terminal count to capture
//   count_value : registered current count
//   terminal    : count_value equals the latched limit
module count_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic             load_limit,
  input  logic [WIDTH-1:0] limit_in,
  output logic [WIDTH-1:0] count_value,
  output logic             terminal
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] limit_r;

  // Limit register: captured only when a new run is started.
  always_ff @(posedge clk) begin
    if (reset) begin
      limit_r <= {WIDTH{1'b0}};
    end else if (load_limit) begin
      limit_r <= limit_in;
    end
  end

  // Count register: count never passes the limit, so no overflow handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (advance) begin
      if (terminal) begin
        count_r <= {WIDTH{1'b0}};
      end else begin
        count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign terminal    = (count_r == limit_r);
  assign count_value = count_r;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
// Programmable timer controller. Accepts START_ONESHOT / START_PERIODIC /
// STOP / NOP commands over valid/ready, runs count_core up to the latched
// limit and pulses match for one cycle at each terminal count.
// Optional feature macro: COUNTER_CTRL_PRESCALE_EN adds the prescale port
// and a 4-bit divider so the counter advances once every P+1 cycles.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   cmd_valid    : command present
//   cmd_ready    : registered; 1 from the first edge after reset releases
//   cmd_op       : opcode (counter_ctrl_pkg::cmd_op_t)
//   cmd_limit    : terminal count, sampled when a START is accepted
//   prescale     : divider value, sampled on START (macro builds only)
//   count_value  : current count
//   busy         : a run is active
//   match        : one-cycle pulse at terminal count
//   match_count  : saturating matches since the last START
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [3:0]       prescale,
`endif
  output logic [WIDTH-1:0] count_value,
  output logic             busy,
  output logic             match,
  output logic [7:0]       match_count
);

  state_t     state_r;
  state_t     next_state_s;
  logic       cmd_ready_r;
  logic       busy_r;
  logic       match_r;
  logic [7:0] match_count_r;
  logic       busy_next_s;
  logic       match_next_s;
  logic [7:0] match_count_next_s;

  logic       accept_s;
  logic       start_s;
  logic       stop_s;
  logic       periodic_req_s;
  logic       running_s;
  logic       tick_s;
  logic       advance_s;
  logic       wrap_s;
  logic       terminal_s;

  assign accept_s  = cmd_valid && cmd_ready_r;
  assign running_s = (state_r != IDLE);

  // Command decode; NOP is accepted but raises no control strobe.
  always_comb begin
    start_s        = 1'b0;
    stop_s         = 1'b0;
    periodic_req_s = 1'b0;
    if (accept_s) begin
      case (cmd_op_t'(cmd_op))
        CMD_START_ONESHOT:  start_s = 1'b1;
        CMD_START_PERIODIC: begin
          start_s        = 1'b1;
          periodic_req_s = 1'b1;
        end
        CMD_STOP:           stop_s = 1'b1;
        CMD_NOP:            start_s = 1'b0;
        default:            start_s = 1'b0;
      endcase
    end else begin
      start_s        = 1'b0;
      stop_s         = 1'b0;
      periodic_req_s = 1'b0;
    end
  end

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [3:0] div_r;
  logic [3:0] prescale_r;

  assign tick_s = (div_r == prescale_r);

  // Prescale divider: cleared on START, frozen when idle or on STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r      <= 4'd0;
      prescale_r <= 4'd0;
    end else if (start_s) begin
      div_r      <= 4'd0;
      prescale_r <= prescale;
    end else if (running_s && !stop_s) begin
      if (tick_s) begin
        div_r <= 4'd0;
      end else begin
        div_r <= div_r + 4'd1;
      end
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // A START or STOP on the same edge pre-empts any advance (and its match).
  assign advance_s = running_s && tick_s && !start_s && !stop_s;
  assign wrap_s    = advance_s && terminal_s;

  count_core #(
    .WIDTH (WIDTH)
  ) u_count_core (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_s),
    .advance     (advance_s),
    .load_limit  (start_s),
    .limit_in    (cmd_limit),
    .count_value (count_value),
    .terminal    (terminal_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: START restarts from any state, one-shot ends at wrap.
  always_comb begin
    next_state_s = state_r;
    if (start_s) begin
      next_state_s = periodic_req_s ? PERIODIC : ONESHOT;
    end else if (stop_s) begin
      next_state_s = IDLE;
    end else if (wrap_s && (state_r == ONESHOT)) begin
      next_state_s = IDLE;
    end else begin
      next_state_s = state_r;
    end
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    busy_next_s        = (next_state_s != IDLE);
    match_next_s       = wrap_s;
    match_count_next_s = match_count_r;
    if (start_s) begin
      match_count_next_s = 8'd0;
    end else if (wrap_s) begin
      match_count_next_s = sat_inc8(match_count_r);
    end else begin
      match_count_next_s = match_count_r;
    end
  end

  // Output registers; cmd_ready rises on the first edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready_r   <= 1'b0;
      busy_r        <= 1'b0;
      match_r       <= 1'b0;
      match_count_r <= 8'd0;
    end else begin
      cmd_ready_r   <= 1'b1;
      busy_r        <= busy_next_s;
      match_r       <= match_next_s;
      match_count_r <= match_count_next_s;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign busy        = busy_r;
  assign match       = match_r;
  assign match_count = match_count_r;

endmodule
